ram_loader: RTL and testbench
=============================

// Module: ram_loader
// PURPOSE
//  Host-side program loader; the write-side counterpart of the CPU's RAM fetch path.
//  - Accepts a byte stream over a valid/ready handshake.
//  - Holds the CPU, then writes each byte into RAM sequentially from address 0.
//    Each write uses the bus with the MEMORY_ADDRESS_IN / RAM_IN strobes.
//  - Releases the CPU with a one-cycle clear pulse when the stream ends.
//  Sits at top level beside ram, driving the shared bus and OR-ed into the control strobes.
// PARAMETERS
//  DATA_WIDTH  8   bus / RAM word width
//  ADDR_WIDTH  4   RAM address width; RAM depth = 2**ADDR_WIDTH (16)
// PORTS
//  clk            in   1           ungated system clock (not HALT-gated)
//  clear          in   1           synchronous, active-high reset
//  start          in   1           pulse: begin a load session (ignored while busy)
//  in_valid       in   1           host byte valid
//  in_data        in   DATA_WIDTH  host byte
//  in_last        in   1           qualifies in_data as final byte of program
//  in_ready       out  1           loader accepts byte this cycle
//  bus_out        out  DATA_WIDTH  tri-state bus drive; 'z when not driving
//  load_address   out  1           to ram.load_address (MAR <- bus)
//  ram_in         out  1           to ram.ram_in (RAM[MAR] <- bus)
//  cpu_hold       out  1           forces CPU clock gate low (OR-ed with HALT)
//  cpu_clear      out  1           one-cycle CPU clear after load
//  busy           out  1           session in progress
//  done           out  1           one-cycle pulse: session complete
//  bytes_written  out  ADDR_WIDTH+1  bytes written in current/last session
// BEHAVIOUR
//  Reset (clear=1 at posedge):
//   - state=IDLE; outputs in_ready, load_address, ram_in, cpu_hold, cpu_clear, busy, done all 0.
//   - bus_out='z, addr=0, bytes_written=0.
//  FSM (all transitions on posedge clk):
//   IDLE:    start=1 -> HOLD; addr<=0; bytes_written<=0.
//   HOLD:    cpu_hold=1 for one settling cycle -> WAIT.
//   WAIT:    in_ready=1. On in_valid&in_ready: data_q<=in_data, last_q<=in_last -> SETADDR.
//            Otherwise stay in WAIT.
//   SETADDR: bus_out={zero-ext addr}; load_address=1 -> WRITE.
//   WRITE:   bus_out=data_q; ram_in=1; bytes_written++.
//            If last_q or addr==2**ADDR_WIDTH-1 -> RELEASE; else addr++ -> WAIT.
//   RELEASE: cpu_clear=1 for exactly one cycle -> FIN.
//   FIN:     done=1 one cycle -> IDLE; cpu_hold drops to 0 on the IDLE cycle.
//  Signal rules:
//   - busy=1 and cpu_hold=1 in every state except IDLE.
//   - bus_out is driven only in SETADDR/WRITE; load_address and ram_in are never both 1.
//   - in_ready is 1 only in WAIT; in_valid is ignored in every other state.
//   - All outputs are registered or pure state decode; no comb path from in_valid to in_ready.
//  Timing: 3 cycles/byte minimum (WAIT, SETADDR, WRITE); first byte accepted 2 cycles after start.
//  Boundary conditions:
//   - Wrap: the write to address 15 ends the session regardless of in_last; addr never wraps to 0.
//   - start during busy: ignored.
//   - start and clear same cycle: clear wins.
//   - clear mid-session: immediate IDLE, no cpu_clear pulse, no done; RAM keeps bytes already written.
//   - in_last on first byte: single write, then RELEASE.
//   - in_data width DATA_WIDTH; address on bus is zero-extended to DATA_WIDTH.
// STRUCTURE
//  - control_defs.vh gains LOADER_ADDR_WIDTH and the RAM depth constant, shared with ram.
//  - State encoding is localparam-local.
//  - top ORs load_address/ram_in into the CW strobes and cpu_hold into the clock gate.
//  - Single module; no sub-module (tri-state drive is one continuous assign).
// TESTING
//  T1 reset: clear=1 two cycles -> all outputs 0, bus_out='z, bytes_written=0.
//  T2 3-byte load: start; stream 8'h1E, 8'h2F, 8'hE0 (last on 3rd, valid every cycle)
//     -> RAM[0..2]=1E,2F,E0; bytes_written=3; cpu_clear 1 cycle; done 1 cycle after it;
//     session ends with busy=0.
//  T3 full depth: 16 bytes 8'h00..8'h0F, in_last never set
//     -> RAM[i]=i; session ends after addr 15; bytes_written=16; no write to RAM[0] after it.
//  T4 backpressure/gaps: in_valid toggled 1-0-0-1 with values 8'hAA, 8'h55 (last)
//     -> exactly 2 writes; in_ready only in WAIT; no byte accepted twice.
//  T5 clear mid-op: clear asserted during WRITE of 2nd byte of 5
//     -> IDLE next cycle, cpu_hold=0, no cpu_clear/done; RAM[0] written, RAM[2..4] unchanged.
//  T6 start while busy: start pulsed during WAIT of byte 1 -> no restart; addr sequence 0,1,2 intact.

Source files
------------

// File: rtl/ram_loader_pkg.sv
// Shared constants and state type for the host-side RAM program loader.
package ram_loader_pkg;

    localparam int LOADER_DATA_WIDTH = 8;
    localparam int LOADER_ADDR_WIDTH = 4;
    localparam int LOADER_RAM_DEPTH  = 1 << LOADER_ADDR_WIDTH;

    // One state per bus phase of a byte write, plus the session bookends.
    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_HOLD    = 3'd1,
        ST_WAIT    = 3'd2,
        ST_SETADDR = 3'd3,
        ST_WRITE   = 3'd4,
        ST_RELEASE = 3'd5,
        ST_FIN     = 3'd6
    } loader_state_t;

endpackage

// File: rtl/ram_loader.sv
// Host-side program loader: holds the CPU, copies a byte stream into RAM from
// address 0 over the shared bus (MAR load, then RAM write), then releases the
// CPU with a one-cycle clear pulse.
//
// Handshake: a byte transfers on a rising clk edge where in_valid and in_ready
// are both 1. in_ready is a pure decode of the WAIT state, so it never depends
// combinationally on in_valid; in_valid is ignored whenever in_ready is 0.
module ram_loader
    import ram_loader_pkg::*;
#(
    parameter int DATA_WIDTH = LOADER_DATA_WIDTH,
    parameter int ADDR_WIDTH = LOADER_ADDR_WIDTH
) (
    input  logic                  clk,
    input  logic                  clear,
    input  logic                  start,
    input  logic                  in_valid,
    input  logic [DATA_WIDTH-1:0] in_data,
    input  logic                  in_last,
    output logic                  in_ready,
    output logic [DATA_WIDTH-1:0] bus_out,
    output logic                  load_address,
    output logic                  ram_in,
    output logic                  cpu_hold,
    output logic                  cpu_clear,
    output logic                  busy,
    output logic                  done,
    output logic [ADDR_WIDTH:0]   bytes_written,
    output loader_state_t         fsm_state
);

    // Last RAM address; the write there ends the session even without in_last.
    localparam logic [ADDR_WIDTH-1:0] ADDR_MAX = '1;

    loader_state_t         state;
    loader_state_t         state_next;
    logic [ADDR_WIDTH-1:0] addr;
    logic [DATA_WIDTH-1:0] data_q;
    logic                  last_q;
    logic [ADDR_WIDTH:0]   count;
    logic                  end_of_stream;
    logic                  bus_drive;
    logic [DATA_WIDTH-1:0] bus_value;

    assign end_of_stream = last_q || (addr == ADDR_MAX);

    // State register; clear returns to IDLE from anywhere, with no release pulse.
    always_ff @(posedge clk) begin
        if (clear) begin
            state <= ST_IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next-state logic for the per-byte WAIT -> SETADDR -> WRITE loop.
    always_comb begin
        state_next = state;
        case (state)
            ST_IDLE:    if (start) state_next = ST_HOLD;
            ST_HOLD:    state_next = ST_WAIT;
            ST_WAIT:    if (in_valid) state_next = ST_SETADDR;
            ST_SETADDR: state_next = ST_WRITE;
            ST_WRITE:   state_next = end_of_stream ? ST_RELEASE : ST_WAIT;
            ST_RELEASE: state_next = ST_FIN;
            ST_FIN:     state_next = ST_IDLE;
            default:    state_next = ST_IDLE;
        endcase
    end

    // Datapath: capture the accepted byte, advance the address and the write count.
    always_ff @(posedge clk) begin
        if (clear) begin
            addr   <= '0;
            data_q <= '0;
            last_q <= 1'b0;
            count  <= '0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (start) begin
                        addr  <= '0;
                        count <= '0;
                    end
                end
                ST_WAIT: begin
                    if (in_valid) begin
                        data_q <= in_data;
                        last_q <= in_last;
                    end
                end
                ST_WRITE: begin
                    count <= count + 1'b1;
                    // The address stops at the top so it never wraps back to 0.
                    if (!end_of_stream) begin
                        addr <= addr + 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

    // Output decode: every strobe is a pure function of the registered state.
    always_comb begin
        in_ready     = 1'b0;
        load_address = 1'b0;
        ram_in       = 1'b0;
        cpu_clear    = 1'b0;
        done         = 1'b0;
        bus_drive    = 1'b0;
        bus_value    = '0;
        case (state)
            ST_WAIT: in_ready = 1'b1;
            ST_SETADDR: begin
                load_address = 1'b1;
                bus_drive    = 1'b1;
                bus_value    = DATA_WIDTH'(addr);
            end
            ST_WRITE: begin
                ram_in    = 1'b1;
                bus_drive = 1'b1;
                bus_value = data_q;
            end
            ST_RELEASE: cpu_clear = 1'b1;
            ST_FIN:     done      = 1'b1;
            default: ;
        endcase
    end

    assign busy          = (state != ST_IDLE);
    assign cpu_hold      = (state != ST_IDLE);
    assign bytes_written = count;
    assign fsm_state     = state;

    // The loader only owns the shared bus during its two bus phases.
    assign bus_out = bus_drive ? bus_value : 'z;

endmodule

// File: tb/tb_ram_loader.sv
// Bench for ram_loader: a bus-level RAM image rebuilt from the MAR/RAM strobes,
// compared against the write list expected from the byte stream.
module tb_ram_loader;

    localparam int DW    = 8;
    localparam int AW    = 4;
    localparam int DEPTH = 16;

    logic          clk = 1'b0;
    logic          clear;
    logic          start;
    logic          in_valid;
    logic [DW-1:0] in_data;
    logic          in_last;
    logic          in_ready;
    wire  [DW-1:0] bus_out;
    logic          load_address;
    logic          ram_in;
    logic          cpu_hold;
    logic          cpu_clear;
    logic          busy;
    logic          done;
    logic [AW:0]   bytes_written;
    logic [2:0]    fsm_state;

    ram_loader #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) dut (
        .clk           (clk),
        .clear         (clear),
        .start         (start),
        .in_valid      (in_valid),
        .in_data       (in_data),
        .in_last       (in_last),
        .in_ready      (in_ready),
        .bus_out       (bus_out),
        .load_address  (load_address),
        .ram_in        (ram_in),
        .cpu_hold      (cpu_hold),
        .cpu_clear     (cpu_clear),
        .busy          (busy),
        .done          (done),
        .bytes_written (bytes_written),
        .fsm_state     (fsm_state)
    );

    // ---------------- clock ----------------
    always #5 clk = ~clk;

    // ---------------- bookkeeping ----------------
    int total = 0;
    int bad   = 0;
    int viol  = 0;
    int cyc   = 0;
    int n_clear, n_done, clear_cyc, done_cyc;

    logic [DW-1:0]    ram_img [DEPTH];
    logic [DW-1:0]    exp_ram [DEPTH];
    logic [AW-1:0]    mar;
    logic [AW+DW-1:0] act_q [$];
    logic [AW+DW-1:0] exp_q [$];
    int               exp_n;

    logic [DW-1:0] stim_data [32];
    logic          stim_last [32];

    typedef struct {
        int          n;
        int          last_at;   // -1: in_last never set
        int          gap_max;   // random idle WAIT cycles before each byte
        int          dmode;     // 0 random, 1 ramp, 2 fixed bytes (msb first)
        logic [31:0] fixed;
        int          exp_bw;
    } vec_t;

    vec_t vecs [7];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h want %0h", name, act, exp);
        end
    endtask

    // ---------------- monitor: RAM rebuilt from bus strobes, signal rules ----------------
    always @(negedge clk) begin
        cyc++;
        if (load_address) mar = bus_out[AW-1:0];
        if (ram_in) begin
            ram_img[mar] = bus_out;
            act_q.push_back({mar, bus_out});
        end
        if (cpu_clear) begin n_clear++; clear_cyc = cyc; end
        if (done)      begin n_done++;  done_cyc  = cyc; end
        if ((load_address && ram_in) || (cpu_hold !== busy) ||
            (in_ready && (!busy || load_address || ram_in || cpu_clear || done)) ||
            ((load_address || ram_in || cpu_clear || done) && !busy)) begin
            viol++;
            if (viol <= 5)
                $display("FAIL rules at cycle %0d: la=%b ri=%b rdy=%b hold=%b busy=%b", cyc,
                         load_address, ram_in, in_ready, cpu_hold, busy);
        end
    end

    // ---------------- reference model: which writes a stream should produce ----------------
    task automatic model_session(input int n);
        exp_q.delete();
        exp_n = 0;
        for (int i = 0; i < n; i++) begin
            if (exp_n == DEPTH) break;
            exp_q.push_back({AW'(exp_n), stim_data[i]});
            exp_ram[exp_n] = stim_data[i];
            exp_n++;
            if (stim_last[i]) break;
        end
    endtask

    task automatic check_ram(input string tag);
        for (int a = 0; a < DEPTH; a++)
            check($sformatf("%s ram[%0d]", tag, a), ram_img[a], exp_ram[a]);
    endtask

    // ---------------- driver: one full session ----------------
    task automatic run_stream(input int n, input int gap_max, input int gap_fixed,
                              input bit poke_start, input int exp_bw, input string tag);
        int idx = 0;
        int budget = 0;
        int gap_left = 0;
        int accepted_n = 0;
        bit will_accept;
        bit poked = 0;
        bit ended = 0;
        bit bw_checked = 0;
        model_session(n);
        act_q.delete();
        n_clear = 0;
        n_done  = 0;
        @(negedge clk); start = 1'b1;
        @(negedge clk); start = 1'b0;
        check({tag, " hold"}, {busy, cpu_hold, in_ready}, 3'b110);
        while (!ended && budget < 600) begin
            if (done) ended = 1;
            if (in_ready && !bw_checked) begin
                check({tag, " bw start"}, bytes_written, 0);
                bw_checked = 1;
            end
            if (poke_start && !poked && in_ready) begin
                start    = 1'b1;
                in_valid = 1'b0;
                poked    = 1;
            end else begin
                start = 1'b0;
                if (idx < n && gap_left == 0) begin
                    in_valid = 1'b1;
                    in_data  = stim_data[idx];
                    in_last  = stim_last[idx];
                end else begin
                    in_valid = 1'b0;
                    in_data  = DW'($urandom);
                    in_last  = 1'($urandom_range(0, 1));
                    if (in_ready && gap_left > 0) gap_left--;
                end
            end
            will_accept = in_valid && in_ready;
            @(negedge clk);
            budget++;
            if (will_accept) begin
                idx++;
                accepted_n++;
                gap_left = (gap_fixed >= 0) ? gap_fixed :
                           (gap_max > 0) ? int'($urandom_range(0, gap_max)) : 0;
            end
        end
        in_valid = 1'b0;
        start    = 1'b0;
        if (!ended) begin
            bad++; total++;
            $display("FAIL %s timeout: got no done want done within 600 cycles", tag);
        end
        @(negedge clk);
        check({tag, " accepted"}, accepted_n, exp_n);
        check({tag, " bw model"}, bytes_written, exp_n);
        check({tag, " bw table"}, bytes_written, exp_bw);
        check({tag, " writes"}, act_q.size(), exp_q.size());
        for (int i = 0; i < exp_q.size() && i < act_q.size(); i++)
            check($sformatf("%s write%0d", tag, i), act_q[i], exp_q[i]);
        check({tag, " cpu_clear"}, n_clear, 1);
        check({tag, " done"}, n_done, 1);
        check({tag, " done after clear"}, done_cyc - clear_cyc, 1);
        check({tag, " idle"}, {busy, cpu_hold, in_ready}, 3'b000);
        check_ram(tag);
    endtask

    task automatic fill_vec(input vec_t v);
        for (int i = 0; i < v.n; i++) begin
            case (v.dmode)
                1:       stim_data[i] = DW'(i);
                2:       stim_data[i] = v.fixed[31 - 8*i -: 8];
                default: stim_data[i] = DW'($urandom);
            endcase
            stim_last[i] = (i == v.last_at);
        end
    endtask

    // ---------------- main ----------------
    initial begin
        int idx;
        int budget;
        bit will_accept;
        for (int a = 0; a < DEPTH; a++) begin
            ram_img[a] = '0;
            exp_ram[a] = '0;
        end
        mar      = '0;
        in_valid = 1'b0;
        in_data  = '0;
        in_last  = 1'b0;
        n_clear  = 0;
        n_done   = 0;
        clear_cyc = 0;
        done_cyc  = 0;

        vecs[0] = '{n: 3,  last_at: 2,  gap_max: 0, dmode: 2, fixed: 32'h1E2FE000, exp_bw: 3};
        vecs[1] = '{n: 16, last_at: -1, gap_max: 0, dmode: 1, fixed: 32'h0,        exp_bw: 16};
        vecs[2] = '{n: 1,  last_at: 0,  gap_max: 0, dmode: 0, fixed: 32'h0,        exp_bw: 1};
        vecs[3] = '{n: 20, last_at: -1, gap_max: 2, dmode: 0, fixed: 32'h0,        exp_bw: 16};
        vecs[4] = '{n: 7,  last_at: 6,  gap_max: 3, dmode: 0, fixed: 32'h0,        exp_bw: 7};
        vecs[5] = '{n: 16, last_at: 15, gap_max: 1, dmode: 1, fixed: 32'h0,        exp_bw: 16};
        vecs[6] = '{n: 8,  last_at: 4,  gap_max: 2, dmode: 0, fixed: 32'h0,        exp_bw: 5};

        // T1: reset, with start asserted alongside clear (clear wins)
        clear = 1'b1;
        start = 1'b1;
        @(negedge clk);
        @(negedge clk);
        check("reset outputs", {in_ready, load_address, ram_in, cpu_hold, cpu_clear, busy, done},
              7'b0);
        check("reset bytes_written", bytes_written, 0);
        clear = 1'b0;
        start = 1'b0;
        @(negedge clk);
        check("start under clear ignored", {busy, cpu_hold}, 2'b00);

        // Table-driven sessions
        for (int v = 0; v < 7; v++) begin
            fill_vec(vecs[v]);
            run_stream(vecs[v].n, vecs[v].gap_max, -1, 1'b0, vecs[v].exp_bw,
                       $sformatf("vec%0d", v));
        end

        // T4: in_valid pattern 1-0-0-1 across WAIT cycles
        stim_data[0] = 8'hAA; stim_last[0] = 1'b0;
        stim_data[1] = 8'h55; stim_last[1] = 1'b1;
        run_stream(2, 0, 2, 1'b0, 2, "gaps");

        // T6: start pulsed during WAIT of byte 1
        for (int i = 0; i < 3; i++) begin
            stim_data[i] = DW'($urandom);
            stim_last[i] = (i == 2);
        end
        run_stream(3, 0, -1, 1'b1, 3, "restart");

        // T5: clear during WRITE of the 2nd of 5 bytes
        for (int i = 0; i < 5; i++) begin
            stim_data[i] = DW'($urandom);
            stim_last[i] = 1'b0;
        end
        exp_ram[0] = stim_data[0];
        exp_ram[1] = stim_data[1];
        n_clear = 0;
        n_done  = 0;
        idx     = 0;
        budget  = 0;
        @(negedge clk); start = 1'b1;
        @(negedge clk); start = 1'b0;
        while (!(ram_in && idx == 2) && budget < 100) begin
            in_valid = (idx < 5);
            in_data  = stim_data[idx];
            in_last  = 1'b0;
            will_accept = in_valid && in_ready;
            @(negedge clk);
            budget++;
            if (will_accept) idx++;
        end
        check("abort reached 2nd write", {ram_in, 4'(idx)}, {1'b1, 4'd2});
        in_valid = 1'b0;
        clear    = 1'b1;
        @(negedge clk);
        clear = 1'b0;
        check("abort idle", {busy, cpu_hold, in_ready, cpu_clear, done}, 5'b0);
        in_valid = 1'b1;
        idx      = 0;
        for (int c = 0; c < 6; c++) begin
            if (in_ready) idx++;
            @(negedge clk);
        end
        in_valid = 1'b0;
        check("abort no accepts", idx, 0);
        check("abort no cpu_clear", n_clear, 0);
        check("abort no done", n_done, 0);
        check("abort ram[0]", ram_img[0], exp_ram[0]);
        for (int a = 2; a < 5; a++)
            check($sformatf("abort ram[%0d]", a), ram_img[a], exp_ram[a]);

        check("signal rules", viol, 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
